// File: rtl/aes_iter_core_pkg.sv
// Shared AES-128 constants, lookup tables and FSM state type for the iterative core.
package aes_iter_core_pkg;

  localparam int BLOCK_W    = 128;
  localparam int NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsmState_e;

  // Entry r occupies the r-th byte from the MSB; round 0 and 11..15 map to zero.
  localparam logic [127:0] RCON_TABLE =
    128'h00_01_02_04_08_10_20_40_80_1b_36_00_00_00_00_00;

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[~{x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    return RCON_TABLE[~{r, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES-128 encryption round together with the matching key-expansion step.
module aes_round_unit
  import aes_iter_core_pkg::*;
(
  input  logic [BLOCK_W-1:0] stateIn,
  input  logic [BLOCK_W-1:0] keyIn,
  input  logic [3:0]         roundNum,
  input  logic               finalRound,
  output logic [BLOCK_W-1:0] stateOut,
  output logic [BLOCK_W-1:0] keyOut
);

  logic [31:0] subRot, k0, k1, k2, k3;
  logic [BLOCK_W-1:0] shifted, mixed;

  assign subRot = {sbox(keyIn[23:16]), sbox(keyIn[15:8]), sbox(keyIn[7:0]), sbox(keyIn[31:24])}
                ^ {rcon(roundNum), 24'h000000};
  assign k0 = keyIn[127:96] ^ subRot;
  assign k1 = keyIn[95:64] ^ k0;
  assign k2 = keyIn[63:32] ^ k1;
  assign k3 = keyIn[31:0] ^ k2;
  assign keyOut = {k0, k1, k2, k3};

  // Byte i sits at row i%4, column i/4; ShiftRows pulls row r from column (c+r)%4.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int SRC = (gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4);
    assign shifted[127-8*gi -: 8] = sbox(stateIn[127-8*SRC -: 8]);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shifted[127-32*gi -: 8];
    assign a1 = shifted[119-32*gi -: 8];
    assign a2 = shifted[111-32*gi -: 8];
    assign a3 = shifted[103-32*gi -: 8];
    assign mixed[127-32*gi -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  end

  assign stateOut = (finalRound ? shifted : mixed) ^ keyOut;

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryption core running RPC rounds per clock with valid/ready handshakes.
module aes_iter_core
  import aes_iter_core_pkg::*;
#(
  parameter int RPC     = 1,
  parameter int OUT_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [BLOCK_W-1:0] in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  fsmState_e          fsmReg, fsmNext;
  logic [BLOCK_W-1:0] stateReg, keyReg, chainState, chainKey;
  logic [3:0]         roundReg;
  logic               lastStep;

  // Each chained copy handles the next consecutive round number.
  for (genvar gi = 0; gi < RPC; gi++) begin : g_round
    logic [BLOCK_W-1:0] sIn, kIn, sOut, kOut;
    logic [3:0]         rnd;
    if (gi == 0) begin : g_first
      assign sIn = stateReg;
      assign kIn = keyReg;
    end else begin : g_next
      assign sIn = g_round[gi-1].sOut;
      assign kIn = g_round[gi-1].kOut;
    end
    assign rnd = roundReg + 4'(gi);
    aes_round_unit uRound (
      .stateIn   (sIn),
      .keyIn     (kIn),
      .roundNum  (rnd),
      .finalRound(rnd == 4'(NUM_ROUNDS)),
      .stateOut  (sOut),
      .keyOut    (kOut)
    );
  end

  assign chainState = g_round[RPC-1].sOut;
  assign chainKey   = g_round[RPC-1].kOut;
  assign lastStep   = (roundReg == 4'(NUM_ROUNDS - RPC + 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsmReg <= IDLE;
    else     fsmReg <= fsmNext;
  end

  always_comb begin
    fsmNext   = fsmReg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsmReg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsmNext = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (lastStep) fsmNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsmNext = IDLE;
      end
      default: fsmNext = IDLE;
    endcase
  end

  // Counter parks at the final round instead of stepping past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= '0;
      keyReg   <= '0;
      roundReg <= '0;
    end else begin
      case (fsmReg)
        IDLE: if (in_valid) begin
          stateReg <= in_data ^ in_key;
          keyReg   <= in_key;
          roundReg <= 4'd1;
        end
        RUN: begin
          stateReg <= chainState;
          keyReg   <= chainKey;
          roundReg <= lastStep ? 4'(NUM_ROUNDS) : roundReg + 4'(RPC);
        end
        default: ;
      endcase
    end
  end

  if (OUT_REG != 0) begin : g_outReg
    logic [BLOCK_W-1:0] outReg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                         outReg <= '0;
      else if (fsmReg == RUN && lastStep) outReg <= chainState;
    end
    assign out_data = outReg;
  end else begin : g_outDirect
    assign out_data = stateReg;
  end

endmodule
